// File: rtl/data_mem_access.sv
// data_mem_access: single-port word RAM behind memory_control with programmable wait states
module data_mem_access #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ldr_req,
    input  logic              str_req,
    input  logic              rw,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] str_data,
    output logic [DATA_W-1:0] ldr_out,
    output logic              ldr_valid,
    output logic              str_ack,
    output logic              busy,
    output logic              acc_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              is_ld;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              req, ok, done;
    // DEPTH <= 2**ADDR_W, so a full-width compare also rejects nonzero upper address bits
    assign req  = ldr_req | str_req;
    assign ok   = (ldr_req ^ str_req) && (ldr_req == rw) && (address < 32'(DEPTH));
    assign done = (state == ACCESS) && (cnt == 4'd0);
    always_ff @(posedge Clk)
        if (Reset && done && !is_ld) mem[a_q] <= d_q;
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ldr_out   <= '0;
            ldr_valid <= 1'b0;
            str_ack   <= 1'b0;
            busy      <= 1'b0;
            acc_err   <= 1'b0;
        end else begin
            ldr_valid <= 1'b0;
            str_ack   <= 1'b0;
            acc_err   <= 1'b0;
            if (state == IDLE) begin
                if (req && ok) begin
                    state <= ACCESS;
                    busy  <= 1'b1;
                    cnt   <= 4'(WAIT_STATES);
                    a_q   <= address[ADDR_W-1:0];
                    d_q   <= str_data;
                    is_ld <= ldr_req;
                end else begin
                    acc_err <= req;
                end
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                ldr_valid <= is_ld;
                str_ack   <= !is_ld;
                if (is_ld) ldr_out <= mem[a_q];
            end
        end
    end
endmodule
